// File: rtl/icache_pkg.sv
// Shared definitions for the instruction/data cache family: refill FSM
// states, replacement-mode selectors and the xorshift-16 victim generator.
package icache_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int REPL_RANDOM = 0;
    localparam int REPL_RR     = 1;

    // One xorshift-16 step (shifts 7, 9, 13); a nonzero state never reaches zero.
    function automatic logic [15:0] xorshift16(input logic [15:0] x);
        logic [15:0] y;
        y = x ^ (x >> 7);
        y = y ^ (y << 9);
        y = y ^ (y >> 13);
        return y;
    endfunction

endpackage

// File: rtl/icache_fa_if.sv
// Fetch-side and memory-side signals of the fully-associative icache.
//
// Miss handshake: mem_req rises the cycle after a fetch miss is detected and
// stays high, with mem_addr stable, until a cycle in which mem_ack is high.
// That ack cycle transfers mem_data (an ack in the first req cycle is legal);
// mem_req drops on the following cycle. mem_ack while mem_req is low is ignored.
// The fetch side has no back-pressure: cache_hit is valid in the same cycle.
interface icache_fa_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic [ADDR_W-1:0] curr_PC;
    logic              fetch_req;
    logic [LINE_W-1:0] cache_entry;
    logic              cache_hit;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data;
    logic              invalidate;
    logic              inv_one;
    logic [ADDR_W-1:0] inv_addr;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    // Cache side
    modport slave (
        input  curr_PC, fetch_req, mem_ack, mem_data, invalidate, inv_one, inv_addr,
        output cache_entry, cache_hit, busy, mem_req, mem_addr, hit_cnt, miss_cnt
    );

    // Fetch stage / memory side
    modport master (
        output curr_PC, fetch_req, mem_ack, mem_data, invalidate, inv_one, inv_addr,
        input  cache_entry, cache_hit, busy, mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_victim_sel.sv
// Victim picker: lowest-index free entry first, otherwise the replacement
// policy chosen at elaboration (pseudo-random LFSR bits or round-robin pointer).
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int ENTRIES   = 32,
    parameter int REPL_MODE = 0,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_lfsr,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_victim,
    output logic               o_all_valid
);

    // Scan downwards so the lowest free index is the last one written.
    always_comb begin
        o_victim    = (REPL_MODE == REPL_RR) ? i_rr_ptr : i_lfsr;
        o_all_valid = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_victim    = IDX_W'(i);
                o_all_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_fa.sv
// Fully-associative instruction-pack cache with combinational lookup and a
// two-state refill FSM. Tags/valid bits live in flops; the data array is a
// plain register array so it can later be swapped for an SRAM macro.
module icache_fa
    import icache_pkg::*;
#(
    parameter int          ADDR_W    = 28,
    parameter int          LINE_W    = 128,
    parameter int          ENTRIES   = 32,
    parameter int          REPL_MODE = 0,
    parameter logic [15:0] LFSR_SEED = 16'hABCD
) (
    input  logic       clk,
    input  logic       rst,
    icache_fa_if.slave bus,
    output state_t     o_dbg_state
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ADDR_W-1:0]  r_tag  [ENTRIES];
    logic [LINE_W-1:0]  r_data [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] w_valid_nxt;
    state_t             r_state;
    logic               r_mem_req;
    logic               r_drop;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [15:0]        r_hit_cnt;
    logic [15:0]        r_miss_cnt;
    logic [15:0]        r_lfsr;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   w_victim;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_hit;
    logic               w_all_valid;
    logic               w_fill;

    icache_victim_sel #(
        .ENTRIES   (ENTRIES),
        .REPL_MODE (REPL_MODE),
        .IDX_W     (IDX_W)
    ) u_victim (
        .i_valid     (r_valid),
        .i_lfsr      (r_lfsr[IDX_W-1:0]),
        .i_rr_ptr    (r_rr),
        .o_victim    (w_victim),
        .o_all_valid (w_all_valid)
    );

    // Tag match; scanning downwards makes the lowest matching index win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == bus.curr_PC)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // A fill needs an ack in WAIT that is neither dropped nor overridden by a flush.
    assign w_fill = (r_state == ST_WAIT) && bus.mem_ack && !r_drop && !bus.invalidate && !rst;

    // Next valid vector: fill, then single-address invalidate (compared against
    // the post-fill tag so a same-address fill stays invalid), then full flush.
    always_comb begin
        logic [ADDR_W-1:0] v_tag;
        w_valid_nxt = r_valid;
        if (w_fill) begin
            w_valid_nxt[w_victim] = 1'b1;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            v_tag = (w_fill && (w_victim == IDX_W'(i))) ? r_mem_addr : r_tag[i];
            if (bus.inv_one && (v_tag == bus.inv_addr)) begin
                w_valid_nxt[i] = 1'b0;
            end
        end
        if (bus.invalidate) begin
            w_valid_nxt = '0;
        end
    end

    // Tag and data storage; not reset because valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_victim]  <= r_mem_addr;
            r_data[w_victim] <= bus.mem_data;
        end
    end

    // Valid bits and replacement state; the LFSR holds only on fill cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_rr    <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_fill && w_all_valid && (REPL_MODE == REPL_RR)) begin
                r_rr <= r_rr + IDX_W'(1);
            end
            if (!w_fill) begin
                r_lfsr <= xorshift16(r_lfsr);
            end
        end
    end

    // Refill FSM with registered request, miss address, drop flag and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_drop     <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fetch_req && w_hit && (r_hit_cnt != 16'hFFFF)) begin
                        r_hit_cnt <= r_hit_cnt + 16'd1;
                    end
                    if (bus.fetch_req && !w_hit && !bus.invalidate) begin
                        r_mem_addr <= bus.curr_PC;
                        r_mem_req  <= 1'b1;
                        r_drop     <= 1'b0;
                        r_state    <= ST_WAIT;
                        if (r_miss_cnt != 16'hFFFF) begin
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.invalidate) begin
                        r_drop <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cache_hit   = w_hit;
    assign bus.cache_entry = r_data[w_hit_idx];
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.hit_cnt     = r_hit_cnt;
    assign bus.miss_cnt    = r_miss_cnt;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_icache_fa.sv
// Bench for icache_fa: a round-robin instance and a pseudo-random instance
// share one stimulus stream; each is compared with its own array-based model.
module tb_icache_fa;
    import icache_pkg::*;

    localparam int AW = 28;
    localparam int LW = 128;
    localparam int NE = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] pc        = '0;
    logic [AW-1:0] inv_addr  = '0;
    logic          fetch_req = 1'b0;
    logic          mem_ack   = 1'b0;
    logic          invalidate = 1'b0;
    logic          inv_one   = 1'b0;
    logic [LW-1:0] mem_data  = '0;

    icache_fa_if #(.ADDR_W(AW), .LINE_W(LW)) bus_r ();
    icache_fa_if #(.ADDR_W(AW), .LINE_W(LW)) bus_p ();

    assign bus_r.curr_PC = pc;      assign bus_p.curr_PC = pc;
    assign bus_r.fetch_req = fetch_req; assign bus_p.fetch_req = fetch_req;
    assign bus_r.mem_ack = mem_ack; assign bus_p.mem_ack = mem_ack;
    assign bus_r.mem_data = mem_data; assign bus_p.mem_data = mem_data;
    assign bus_r.invalidate = invalidate; assign bus_p.invalidate = invalidate;
    assign bus_r.inv_one = inv_one; assign bus_p.inv_one = inv_one;
    assign bus_r.inv_addr = inv_addr; assign bus_p.inv_addr = inv_addr;

    state_t st_r, st_p;

    icache_fa #(.ADDR_W(AW), .LINE_W(LW), .ENTRIES(NE), .REPL_MODE(REPL_RR),
                .LFSR_SEED(16'hABCD)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r), .o_dbg_state(st_r));

    icache_fa #(.ADDR_W(AW), .LINE_W(LW), .ENTRIES(NE), .REPL_MODE(REPL_RANDOM),
                .LFSR_SEED(16'hABCD)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p), .o_dbg_state(st_p));

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model (index 0 = round-robin, 1 = random) ----
    logic          m_valid [2][NE];
    logic [AW-1:0] m_tag   [2][NE];
    logic [LW-1:0] m_data  [2][NE];
    int            m_lfsr  [2];
    int            m_rr    [2];
    bit            m_wait  [2];
    bit            m_drop  [2];
    logic [AW-1:0] m_addr  [2];
    int            m_hit   [2];
    int            m_miss  [2];

    function automatic int xs16(input int x);
        int t;
        t = x & 'hFFFF;
        t = t ^ (t >> 7);
        t = (t ^ (t << 9)) & 'hFFFF;
        t = t ^ (t >> 13);
        return t;
    endfunction

    function automatic int m_lookup(input int k, input logic [AW-1:0] a);
        for (int i = 0; i < NE; i++)
            if (m_valid[k][i] && m_tag[k][i] == a) return i;
        return -1;
    endfunction

    task automatic m_step(input int k, input int mode);
        int hidx;
        int v;
        bit fill;
        if (rst) begin
            for (int i = 0; i < NE; i++) m_valid[k][i] = 1'b0;
            m_wait[k] = 0; m_drop[k] = 0; m_addr[k] = '0;
            m_hit[k] = 0; m_miss[k] = 0; m_rr[k] = 0; m_lfsr[k] = 'hABCD;
            return;
        end
        fill = 0;
        hidx = m_lookup(k, pc);
        if (!m_wait[k]) begin
            if (fetch_req && hidx >= 0 && m_hit[k] < 65535) m_hit[k]++;
            if (fetch_req && hidx < 0 && !invalidate) begin
                m_wait[k] = 1; m_drop[k] = 0; m_addr[k] = pc;
                if (m_miss[k] < 65535) m_miss[k]++;
            end
        end else begin
            if (invalidate) m_drop[k] = 1;
            if (mem_ack) begin
                if (!m_drop[k]) begin
                    v = -1;
                    for (int i = 0; i < NE; i++)
                        if (!m_valid[k][i]) begin v = i; break; end
                    if (v < 0) begin
                        if (mode == 1) begin v = m_rr[k]; m_rr[k] = (m_rr[k] + 1) % NE; end
                        else v = m_lfsr[k] % NE;
                    end
                    m_tag[k][v] = m_addr[k]; m_data[k][v] = mem_data;
                    m_valid[k][v] = 1'b1; fill = 1;
                end
                m_wait[k] = 0; m_drop[k] = 0;
            end
        end
        if (inv_one)
            for (int i = 0; i < NE; i++)
                if (m_valid[k][i] && m_tag[k][i] == inv_addr) m_valid[k][i] = 1'b0;
        if (invalidate)
            for (int i = 0; i < NE; i++) m_valid[k][i] = 1'b0;
        if (!fill) m_lfsr[k] = xs16(m_lfsr[k]);
    endtask

    always @(posedge clk) begin
        m_step(0, 1);
        m_step(1, 0);
    end

    // ---------------- drivers ------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fetch_req = 0; mem_ack = 0; invalidate = 0; inv_one = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Call at a negedge: one fetch cycle, n wait cycles, one ack cycle.
    task automatic drive_fill(input logic [AW-1:0] a, input logic [LW-1:0] d,
                              input int n, input bit inv, input logic [AW-1:0] ia);
        pc = a; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (n) @(negedge clk);
        mem_data = d; mem_ack = 1'b1; inv_one = inv; inv_addr = ia;
        @(negedge clk);
        mem_ack = 1'b0; inv_one = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", bus_r.cache_hit); else n_pass++;
        n_total++; if (bus_r.mem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus_r.mem_req); else n_pass++;
        n_total++; if (bus_r.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus_r.busy); else n_pass++;
        n_total++; if (bus_r.mem_addr !== '0) $display("FAIL reset_addr: got %0h want 0", bus_r.mem_addr); else n_pass++;
        n_total++; if (bus_r.hit_cnt !== 16'd0 || bus_r.miss_cnt !== 16'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus_r.hit_cnt, bus_r.miss_cnt); else n_pass++;
        n_total++; if (st_p !== ST_IDLE) $display("FAIL reset_state: got %0d want IDLE", st_p); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_miss_refill();
        logic [LW-1:0] d;
        d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        @(negedge clk);
        pc = 28'h0000100; fetch_req = 1'b1; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL first_miss: got %0b want 0", bus_r.cache_hit); else n_pass++;
        @(negedge clk);
        fetch_req = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b1 || bus_r.busy !== 1'b1) $display("FAIL req_rise: req %0b busy %0b want 1 1", bus_r.mem_req, bus_r.busy); else n_pass++;
        n_total++; if (bus_r.mem_addr !== 28'h0000100) $display("FAIL miss_addr: got %0h want 100", bus_r.mem_addr); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (bus_r.mem_req !== 1'b1) $display("FAIL req_held: got %0b want 1", bus_r.mem_req); else n_pass++;
        mem_data = d; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b0) $display("FAIL req_drop: got %0b want 0", bus_r.mem_req); else n_pass++;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL refill_hit: got %0b want 1", bus_r.cache_hit); else n_pass++;
        n_total++; if (bus_r.cache_entry !== d) $display("FAIL refill_data: got %0h want %0h", bus_r.cache_entry, d); else n_pass++;
        n_total++; if (bus_r.miss_cnt !== 16'd1) $display("FAIL miss_cnt1: got %0d want 1", bus_r.miss_cnt); else n_pass++;
        fetch_req = 1'b1;
        repeat (4) @(negedge clk);
        fetch_req = 1'b0;
        n_total++; if (bus_r.hit_cnt !== 16'd4) $display("FAIL hit_cnt4: got %0d want 4", bus_r.hit_cnt); else n_pass++;
        n_total++; if (bus_r.mem_req !== 1'b0 || bus_r.miss_cnt !== 16'd1) $display("FAIL hit_noreq: req %0b miss %0d want 0 1", bus_r.mem_req, bus_r.miss_cnt); else n_pass++;
    endtask

    task automatic test_fill_all();
        logic [AW-1:0] used_q[$];
        logic [AW-1:0] a;
        int idx;
        int ev;
        do_reset();
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            drive_fill(AW'(i), rnd_line(), $urandom_range(0, 2), 1'b0, '0);
            used_q.push_back(AW'(i));
        end
        // round-robin: first replacement takes entry 0, second entry 1
        @(negedge clk);
        drive_fill(28'h40, rnd_line(), $urandom_range(0, 2), 1'b0, '0);
        pc = 28'h0; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL rr_evict0: got %0b want 0", bus_r.cache_hit); else n_pass++;
        pc = 28'h40; #1;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL rr_new40: got %0b want 1", bus_r.cache_hit); else n_pass++;
        ev = -1;
        for (int i = 0; i < NE; i++) if (m_valid[1][i] && m_tag[1][i] == 28'h40) ev = i;
        pc = AW'(ev); #1;
        n_total++; if (bus_p.cache_hit !== 1'b0) $display("FAIL lfsr_evict: pc %0h hit %0b want 0", pc, bus_p.cache_hit); else n_pass++;
        @(negedge clk);
        drive_fill(28'h41, rnd_line(), $urandom_range(0, 2), 1'b0, '0);
        pc = 28'h1; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL rr_evict1: got %0b want 0", bus_r.cache_hit); else n_pass++;
        pc = 28'h2; #1;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL rr_keep2: got %0b want 1", bus_r.cache_hit); else n_pass++;
        used_q.push_back(28'h40); used_q.push_back(28'h41);
        for (int j = 0; j < 6; j++) begin
            a = AW'(28'h1000 + $urandom_range(0, 255));
            @(negedge clk);
            drive_fill(a, rnd_line(), $urandom_range(0, 2), 1'b0, '0);
            used_q.push_back(a);
        end
        foreach (used_q[j]) begin
            pc = used_q[j]; #1;
            idx = m_lookup(0, pc);
            n_total++; if (bus_r.cache_hit !== (idx >= 0)) $display("FAIL scan_rr_hit pc %0h: got %0b", pc, bus_r.cache_hit); else n_pass++;
            if (idx >= 0) begin
                n_total++; if (bus_r.cache_entry !== m_data[0][idx]) $display("FAIL scan_rr_data pc %0h: got %0h want %0h", pc, bus_r.cache_entry, m_data[0][idx]); else n_pass++;
            end
            idx = m_lookup(1, pc);
            n_total++; if (bus_p.cache_hit !== (idx >= 0)) $display("FAIL scan_rnd_hit pc %0h: got %0b", pc, bus_p.cache_hit); else n_pass++;
            if (idx >= 0) begin
                n_total++; if (bus_p.cache_entry !== m_data[1][idx]) $display("FAIL scan_rnd_data pc %0h: got %0h want %0h", pc, bus_p.cache_entry, m_data[1][idx]); else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalidate_wait();
        do_reset();
        @(negedge clk);
        drive_fill(28'h100, rnd_line(), 1, 1'b0, '0);
        pc = 28'h200; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        @(negedge clk);
        n_total++; if (bus_r.mem_req !== 1'b1) $display("FAIL drop_req_held: got %0b want 1", bus_r.mem_req); else n_pass++;
        mem_data = rnd_line(); mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_total++; if (st_r !== ST_IDLE || bus_r.mem_req !== 1'b0) $display("FAIL drop_idle: state %0d req %0b want IDLE 0", st_r, bus_r.mem_req); else n_pass++;
        pc = 28'h100; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL flush_old: got %0b want 0", bus_r.cache_hit); else n_pass++;
        pc = 28'h200; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0 || bus_p.cache_hit !== 1'b0) $display("FAIL drop_nofill: got %0b %0b want 0 0", bus_r.cache_hit, bus_p.cache_hit); else n_pass++;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b1 || bus_r.miss_cnt !== 16'd3) $display("FAIL refetch_miss: req %0b miss %0d want 1 3", bus_r.mem_req, bus_r.miss_cnt); else n_pass++;
        mem_data = rnd_line(); mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_inv_one();
        int idx;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_fill(AW'(28'h100 + i), rnd_line(), $urandom_range(0, 2), 1'b0, '0);
        end
        inv_one = 1'b1; inv_addr = 28'h100;
        @(negedge clk);
        inv_one = 1'b0;
        pc = 28'h100; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL inv_one_gone: got %0b want 0", bus_r.cache_hit); else n_pass++;
        pc = 28'h101; #1;
        idx = m_lookup(0, pc);
        n_total++; if (bus_r.cache_hit !== 1'b1 || idx < 0) $display("FAIL inv_one_keep101: got %0b want 1", bus_r.cache_hit);
        else if (bus_r.cache_entry !== m_data[0][idx]) $display("FAIL inv_one_data101: got %0h want %0h", bus_r.cache_entry, m_data[0][idx]); else n_pass++;
        pc = 28'h102; #1;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL inv_one_keep102: got %0b want 1", bus_r.cache_hit); else n_pass++;
        @(negedge clk);
        drive_fill(28'h300, rnd_line(), 0, 1'b1, 28'h300);
        pc = 28'h300; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL inv_same_fill: got %0b want 0", bus_r.cache_hit); else n_pass++;
        @(negedge clk);
        drive_fill(28'h301, rnd_line(), 1, 1'b1, 28'h101);
        pc = 28'h301; #1;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL inv_diff_fill: got %0b want 1", bus_r.cache_hit); else n_pass++;
        pc = 28'h101; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL inv_diff_clear: got %0b want 0", bus_r.cache_hit); else n_pass++;
        pc = 28'h102; #1;
        n_total++; if (bus_r.cache_hit !== 1'b1) $display("FAIL inv_diff_keep: got %0b want 1", bus_r.cache_hit); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [AW-1:0] a;
        int idx;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                invalidate = 1'b1;
                @(negedge clk);
                invalidate = 1'b0;
            end
            a = AW'(28'h2000 + $urandom_range(0, 47));
            pc = a; #1;
            idx = m_lookup(0, a);
            n_total++; if (bus_r.cache_hit !== (idx >= 0)) $display("FAIL rt_rr_hit pc %0h: got %0b", a, bus_r.cache_hit); else n_pass++;
            idx = m_lookup(1, a);
            n_total++; if (bus_p.cache_hit !== (idx >= 0)) $display("FAIL rt_rnd_hit pc %0h: got %0b", a, bus_p.cache_hit); else n_pass++;
            if (idx >= 0) begin
                n_total++; if (bus_p.cache_entry !== m_data[1][idx]) $display("FAIL rt_rnd_data pc %0h: got %0h want %0h", a, bus_p.cache_entry, m_data[1][idx]); else n_pass++;
            end
            drive_fill(a, rnd_line(), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                       AW'(28'h2000 + $urandom_range(0, 47)));
            n_total++; if (bus_r.hit_cnt !== 16'(m_hit[0]) || bus_r.miss_cnt !== 16'(m_miss[0]))
                $display("FAIL rt_rr_cnt: got %0d/%0d want %0d/%0d", bus_r.hit_cnt, bus_r.miss_cnt, m_hit[0], m_miss[0]); else n_pass++;
            n_total++; if (bus_p.hit_cnt !== 16'(m_hit[1]) || bus_p.miss_cnt !== 16'(m_miss[1]))
                $display("FAIL rt_rnd_cnt: got %0d/%0d want %0d/%0d", bus_p.hit_cnt, bus_p.miss_cnt, m_hit[1], m_miss[1]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_and_sat();
        do_reset();
        @(negedge clk);
        pc = 28'h500; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b1) $display("FAIL pre_rst_req: got %0b want 1", bus_r.mem_req); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b0 || bus_r.busy !== 1'b0) $display("FAIL rst_mid_req: req %0b busy %0b want 0 0", bus_r.mem_req, bus_r.busy); else n_pass++;
        mem_data = rnd_line(); mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_total++; if (bus_r.mem_req !== 1'b0 || st_r !== ST_IDLE) $display("FAIL stray_ack: req %0b state %0d want 0 IDLE", bus_r.mem_req, st_r); else n_pass++;
        n_total++; if (bus_r.hit_cnt !== 16'd0 || bus_r.miss_cnt !== 16'd0) $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", bus_r.hit_cnt, bus_r.miss_cnt); else n_pass++;
        pc = 28'h500; #1;
        n_total++; if (bus_r.cache_hit !== 1'b0) $display("FAIL stray_nowrite: got %0b want 0", bus_r.cache_hit); else n_pass++;
        @(negedge clk);
        drive_fill(28'h600, rnd_line(), 0, 1'b0, '0);
        pc = 28'h600; fetch_req = 1'b1;
        repeat (65540) @(negedge clk);
        fetch_req = 1'b0;
        n_total++; if (bus_r.hit_cnt !== 16'hFFFF) $display("FAIL hit_sat: got %0h want ffff", bus_r.hit_cnt); else n_pass++;
        n_total++; if (bus_p.hit_cnt !== 16'(m_hit[1]) || bus_r.miss_cnt !== 16'd1) $display("FAIL sat_other: hit %0h miss %0d want %0h 1", bus_p.hit_cnt, bus_r.miss_cnt, m_hit[1]); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_miss_refill();
        test_fill_all();
        test_invalidate_wait();
        test_inv_one();
        test_random_traffic();
        test_reset_mid_and_sat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
